// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types for the bit-serial adder: the FSM state enum, whose
//   encodings come from serial_adder_defs.vh.
package serial_adder_pkg;

  `include "serial_adder_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/serial_add_bit.sv
// serial_add_bit
//   Combinational 1-bit full-adder slice used once per clock by the
//   serial adder.
// Ports:
//   a, b, cin : input bits of the current bit position
//   sum       : a ^ b ^ cin
//   carry     : majority(a, b, cin)
module serial_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  // Full-adder sum and majority carry.
  always_comb begin
    sum   = a ^ b ^ cin;
    carry = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_defs.vh
// serial_adder_defs.vh
//   State encodings shared by the serial adder FSM. The file is included
//   inside serial_adder_pkg, so these constants are package-scoped.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH

localparam logic [1:0] S_IDLE  = 2'd0;
localparam logic [1:0] S_SHIFT = 2'd1;
localparam logic [1:0] S_DONE  = 2'd2;

`endif

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured in parallel on an
//   accepted start. One bit pair per clock is added LSB-first through a
//   single full-adder slice and a carry flop. The assembled word is then
//   presented in parallel together with a one-cycle done pulse.
//   Optional feature macro: SERIAL_ADDER_SUB_EN. When it is defined, the
//   block gets a `sub` input. With sub=1 the block computes a - b: ~b is
//   loaded and the carry flop is forced to 1. carry=1 then means no
//   borrow.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request, sampled only in IDLE or DONE
//   a, b  : WIDTH-bit operands, captured on an accepted start
//   cin   : carry-in, captured on an accepted start (ignored when sub=1)
//   sub   : (SERIAL_ADDER_SUB_EN only) subtract select, captured on start
//   sum   : registered result, holds until the next completion
//   carry : registered carry-out, holds until the next completion
//   busy  : high while shifting
//   done  : one-cycle completion pulse
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 result bits produced so far. The final bit joins
  // them on the last edge.
  logic [WIDTH-2:0] s_sr;
  logic [WIDTH-1:0] s_shift;
  logic             c_ff;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             bit_sum;
  logic             bit_carry;
  logic             last_bit;

  // Single full-adder slice working on the current LSBs.
  serial_add_bit u_add_bit (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (c_ff),
    .sum   (bit_sum),
    .carry (bit_carry)
  );

  // Operand B and carry-in as they are loaded on an accepted start.
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      // Two's complement subtract: a + ~b + 1.
      b_load = ~b;
      c_load = 1'b1;
    end else begin
      b_load = b;
      c_load = cin;
    end
`endif
  end

  // New sum bit enters at the top. The shift register and the final word
  // both take their bits from this view.
  always_comb begin
    s_shift  = {bit_sum, s_sr};
    last_bit = (cnt == CNT_LAST);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_SHIFT;
        else       state_nx = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_bit) state_nx = ST_DONE;
        else          state_nx = ST_SHIFT;
      end
      ST_DONE: begin
        if (start) state_nx = ST_SHIFT;
        else       state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Operand capture and per-bit shifting of the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= {WIDTH{1'b0}};
      b_sr <= {WIDTH{1'b0}};
      s_sr <= {(WIDTH-1){1'b0}};
      c_ff <= 1'b0;
      cnt  <= {CW{1'b0}};
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b_load;
            c_ff <= c_load;
            cnt  <= {CW{1'b0}};
          end
        end
        ST_SHIFT: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          s_sr <= s_shift[WIDTH-1:1];
          c_ff <= bit_carry;
          cnt  <= cnt + CW'(1);
        end
        default: begin
          cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Result registers update only on the final shift edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= {WIDTH{1'b0}};
      carry <= 1'b0;
    end else if ((state == ST_SHIFT) && last_bit) begin
      sum   <= s_shift;
      carry <= bit_carry;
    end
  end

  // Status outputs are registered copies of the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == ST_SHIFT);
      done <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Self-checking bench for serial_adder. The reference model counts WIDTH
//   busy cycles after each accepted start. It then presents a+b+cin (or
//   a-b when subtracting) for one done cycle. Every cycle the DUT outputs
//   are compared with the model. Directed cases pin results and latency.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub_sel = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic [W-1:0] sum;
  logic         carry;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .sum   (sum),
    .carry (carry),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

`ifdef SERIAL_ADDER_SUB_EN
  always_comb sub = sub_sel;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W-1:0] ny;
    ny = ~y;
    if (sb) return {1'b0, x} + {1'b0, ny} + (W+1)'(1);
    else    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // Reference model: remaining busy cycles, done flag and result.
  int         rem = 0;
  logic       m_done = 1'b0;
  logic [W:0] m_res = '0;
  logic [W:0] pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1) begin
        m_res  <= pend;
        m_done <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
        pend <= ref_sum(a, b, cin, sub_sel);
`else
        pend <= ref_sum(a, b, cin, 1'b0);
`endif
        rem  <= W;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("busy", busy, (rem > 0));
      chk("done", done, m_done);
      chk("result", {carry, sum}, m_res);
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  int n;
  int ops;

  initial begin
    // Model pins.
    chk("pin_ff_01", ref_sum(8'hFF, 8'h01, 1'b0, 1'b0), 9'h100);
    chk("pin_3c_5a", ref_sum(8'h3C, 8'h5A, 1'b1, 1'b0), 9'h097);
    chk("pin_sub", ref_sum(8'h05, 8'h07, 1'b0, 1'b1), 9'h0FE);

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sum", sum, 8'h00);
    chk("rst_flags", {carry, busy, done}, 3'b000);
    rst = 1'b0;
    check_en = 1'b1;

    // 1: FF + 01 -> 00 carry 1, done 8 negedges after acceptance cycle.
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(n);
    chk("t1_latency", n, 8);
    chk("t1_result", {carry, sum}, 9'h100);

    // 2: 3C + 5A + 1 -> 97 carry 0.
    issue(8'h3C, 8'h5A, 1'b1);
    wait_done(n);
    chk("t2_latency", n, 8);
    chk("t2_result", {carry, sum}, 9'h097);
    @(negedge clk);
    chk("t2_done_pulse", done, 1'b0);

    // 3: start mid-operation is ignored.
    issue(8'h01, 8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("t3_latency", n, 5);
    chk("t3_result", {carry, sum}, 9'h002);
    count_dones(12, n);
    chk("t3_no_second_done", n, 0);

    // 4: reset three cycles into an operation.
    issue(8'hA5, 8'h5A, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t4_rst_sum", sum, 8'h00);
    chk("t4_rst_flags", {carry, busy, done}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    count_dones(12, n);
    chk("t4_no_done", n, 0);
    issue(8'h80, 8'h80, 1'b1);
    wait_done(n);
    chk("t4_next_result", {carry, sum}, 9'h101);

    // 5: start held high, three back-to-back operations.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1;
    wait_done(n);
    chk("t5_lat1", n, 8);
    chk("t5_res1", {carry, sum}, 9'h046);
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; cin = 1'b1;
    wait_done(n);
    chk("t5_lat2", n, 8);
    chk("t5_res2", {carry, sum}, 9'h100);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("t5_lat3", n, 8);
    chk("t5_res3", {carry, sum}, 9'h0FF);
    repeat (2) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    // 6: subtract 05 - 07 -> FE with borrow.
    sub_sel = 1'b1;
    issue(8'h05, 8'h07, 1'b0);
    sub_sel = 1'b0;
    wait_done(n);
    chk("t6_sub_result", {carry, sum}, 9'h0FE);
`endif

    // Random: starts at random times, including while busy.
    ops = 0;
    for (int i = 0; i < 6000 && ops < 200; i++) begin
      @(negedge clk);
      if (done) ops++;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      sub_sel = 1'($urandom);
`ifndef SERIAL_ADDER_SUB_EN
      sub_sel = 1'b0;
`endif
      start = ($urandom_range(0, 3) != 0);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("random_ops", (ops >= 200), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
